setup_ctrl_m: RTL

- User-input controller that sequences the time-set and alarm-set operations for counter_m and alarm_m.
- Converts three push buttons and an alarm-enable switch into set_flag/set_time and alarm_flag/alarm_time.
- Sits between the physical inputs and the coordination module. It replaces test_m on hardware.
- Editing is done per field (hour/min/sec); internally the block always presents seconds-of-day timestamps (0..86399).

---
 rtl/setup_ctrl_m.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/setup_ctrl_m.sv
// Button/switch front end that sequences time-set (LOAD, SET_H/M/S) and alarm-set (AL_H/M) editing.
// Edits land one cycle after a press; set_time/alarm_time follow the fields one cycle later. No backpressure.
module setup_ctrl_m #(
  parameter int HOLD_CYCLES    = 4,
  parameter int REPEAT_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mode_btn,
  input  logic        inc_btn,
  input  logic        dec_btn,
  input  logic        alarm_sw,
  input  logic [16:0] counter_state,
  output logic        set_flag,
  output logic [16:0] set_time,
  output logic        alarm_flag,
  output logic [16:0] alarm_time,
  output logic [2:0]  edit_field,
  output logic        busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SET_H = 3'd2;
  localparam logic [2:0] S_SET_M = 3'd3;
  localparam logic [2:0] S_SET_S = 3'd4;
  localparam logic [2:0] S_AL_H  = 3'd5;
  localparam logic [2:0] S_AL_M  = 3'd6;

  localparam int HW = $clog2(HOLD_CYCLES + 1) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    state, state_nx;
  logic          mode_q, mode_q2, inc_q, inc_q2, dec_q, dec_q2;
  logic [16:0]   rem;
  logic [5:0]    hr, mn, sc, al_hr, al_mn;
  logic [HW-1:0] hold_cnt, hold_cnt_nx;
  logic [TW-1:0] idle_cnt;

  logic mode_press, inc_press, dec_press;
  logic both, held, activity;
  logic in_edit, in_set, in_al, nx_al;
  logic timeout_hit, step, step_up;

  assign mode_press = mode_q & ~mode_q2;
  assign inc_press  = inc_q & ~inc_q2;
  assign dec_press  = dec_q & ~dec_q2;
  assign both       = inc_q & dec_q;
  assign held       = inc_q | dec_q;
  assign activity   = mode_q | held;

  assign in_set  = (state == S_SET_H) || (state == S_SET_M) || (state == S_SET_S);
  assign in_al   = (state == S_AL_H) || (state == S_AL_M);
  assign in_edit = in_set || in_al;
  assign nx_al   = (state_nx == S_AL_H) || (state_nx == S_AL_M);

  assign timeout_hit = in_edit && !activity && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Single-step wrap inside one field; no carry into neighbouring fields.
  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] top,
                                           input logic up);
    if (up) return (v == top) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (mode_press) state_nx = S_LOAD;
      S_LOAD:  if (rem < 17'd60) state_nx = S_SET_H;
      S_SET_H, S_SET_M, S_SET_S, S_AL_H, S_AL_M: begin
        if (mode_press)       state_nx = (state == S_AL_M) ? S_IDLE : state + 3'd1;
        else if (timeout_hit) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Mode beats inc/dec, and inc+dec together cancel; either case restarts the hold count.
  always_comb begin
    step        = 1'b0;
    step_up     = 1'b0;
    hold_cnt_nx = '0;
    if (in_edit && !mode_press && !both) begin
      if (inc_press || dec_press) begin
        step    = 1'b1;
        step_up = inc_press;
      end else if (held) begin
        step_up = inc_q;
        if (hold_cnt == HW'(HOLD_CYCLES)) begin
          step        = 1'b1;
          hold_cnt_nx = HW'(HOLD_CYCLES - REPEAT_CYCLES + 1);
        end else begin
          hold_cnt_nx = hold_cnt + HW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      mode_q     <= 1'b0;
      mode_q2    <= 1'b0;
      inc_q      <= 1'b0;
      inc_q2     <= 1'b0;
      dec_q      <= 1'b0;
      dec_q2     <= 1'b0;
      rem        <= '0;
      hr         <= '0;
      mn         <= '0;
      sc         <= '0;
      al_hr      <= '0;
      al_mn      <= '0;
      hold_cnt   <= '0;
      idle_cnt   <= '0;
      set_time   <= '0;
      alarm_time <= '0;
      alarm_flag <= 1'b0;
    end else begin
      mode_q   <= mode_btn;
      mode_q2  <= mode_q;
      inc_q    <= inc_btn;
      inc_q2   <= inc_q;
      dec_q    <= dec_btn;
      dec_q2   <= dec_q;
      state    <= state_nx;
      hold_cnt <= hold_cnt_nx;
      idle_cnt <= (!in_edit || activity || timeout_hit) ? '0 : idle_cnt + TW'(1);

      // Forced low while editing and on the first cycle back, so alarm_m never sees a half-edited setpoint.
      alarm_flag <= alarm_sw & ~(in_al | nx_al);

      if (state == S_IDLE && mode_press) begin
        rem      <= counter_state;
        set_time <= counter_state;
        hr       <= '0;
        mn       <= '0;
        sc       <= '0;
      end

      // Split the snapshot into fields by repeated subtraction: one hour or minute per cycle.
      if (state == S_LOAD) begin
        if (rem >= 17'd3600) begin
          rem <= rem - 17'd3600;
          hr  <= hr + 6'd1;
        end else if (rem >= 17'd60) begin
          rem <= rem - 17'd60;
          mn  <= mn + 6'd1;
        end else begin
          sc  <= rem[5:0];
        end
      end

      if (step) begin
        case (state)
          S_SET_H: hr    <= wrap_step(hr, 6'd23, step_up);
          S_SET_M: mn    <= wrap_step(mn, 6'd59, step_up);
          S_SET_S: sc    <= wrap_step(sc, 6'd59, step_up);
          S_AL_H:  al_hr <= wrap_step(al_hr, 6'd23, step_up);
          S_AL_M:  al_mn <= wrap_step(al_mn, 6'd59, step_up);
          default: ;
        endcase
      end

      if (in_set)
        set_time <= 17'(hr) * 17'd3600 + 17'(mn) * 17'd60 + 17'(sc);
      if (in_al)
        alarm_time <= 17'(al_hr) * 17'd3600 + 17'(al_mn) * 17'd60;
    end
  end

  always_comb begin
    edit_field = 3'd0;
    case (state)
      S_SET_H: edit_field = 3'd1;
      S_SET_M: edit_field = 3'd2;
      S_SET_S: edit_field = 3'd3;
      S_AL_H:  edit_field = 3'd4;
      S_AL_M:  edit_field = 3'd5;
      default: edit_field = 3'd0;
    endcase
  end

  assign set_flag = (state == S_LOAD) || in_set;
  assign busy     = (state == S_LOAD);

endmodule
